// File: rtl/act_pkg.sv
// Shared constants for the activation stage: activation mode selects and
// FSM state encodings.
package act_pkg;

  localparam logic [1:0] ACT_BYPASS = 2'd0;
  localparam logic [1:0] ACT_RELU   = 2'd1;
  localparam logic [1:0] ACT_LEAKY  = 2'd2;
  localparam logic [1:0] ACT_CLAMP  = 2'd3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/act_lane.sv
// Combinational activation of one signed neuron value; result keeps the
// input width (no widening).
import act_pkg::*;

module act_lane #(
  parameter int DATA_W     = 16,
  parameter int LEAK_SHIFT = 3
) (
  input  logic signed [DATA_W-1:0] x_i,
  input  logic        [1:0]        mode_i,
  input  logic signed [DATA_W-1:0] cap_i,
  output logic signed [DATA_W-1:0] y_o
);

  logic neg;
  assign neg = x_i[DATA_W-1];

  always_comb begin
    y_o = x_i;
    case (mode_i)
      ACT_BYPASS: y_o = x_i;
      ACT_RELU:   y_o = neg ? '0 : x_i;
      ACT_LEAKY:  y_o = neg ? (x_i >>> LEAK_SHIFT) : x_i;
      // A negative ceiling forces every lane to zero, including positive x.
      ACT_CLAMP: begin
        if (cap_i[DATA_W-1] || neg) y_o = '0;
        else if (x_i > cap_i)       y_o = cap_i;
        else                        y_o = x_i;
      end
      default:    y_o = x_i;
    endcase
  end

endmodule

// File: rtl/act_unit.sv
// Multi-lane activation stage with one-cycle latency and a layer beat
// counter that pulses layer_done when the programmed beat count is reached.
import act_pkg::*;

module act_unit #(
  parameter int DATA_W     = 16,
  parameter int LANES      = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_W      = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [DATA_W-1:0]       cap,
  input  logic [CNT_W-1:0]        layer_len,
  input  logic                    neuron_done,
  input  logic [LANES*DATA_W-1:0] neuron,
  output logic [LANES*DATA_W-1:0] out,
  output logic                    cpu_neuron_done,
  output logic                    layer_done,
  output logic                    busy,
  output logic                    err
);

  // Handshake: a beat is taken when neuron_done is high in RUN; its result
  // appears on out with cpu_neuron_done high exactly one cycle later. There
  // is no backpressure, so a beat may arrive every cycle.

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        len_q, len_d;
  logic [1:0]              mode_q, mode_d;
  logic [DATA_W-1:0]       cap_q, cap_d;
  logic [LANES*DATA_W-1:0] out_q, out_d;
  logic                    vld_q, vld_d;
  logic                    err_q, err_d;
  logic [LANES*DATA_W-1:0] act_w;

  logic start_ok, accept, last_beat;
  assign start_ok  = start && (state_q == IDLE);
  assign accept    = neuron_done && (state_q == RUN);
  assign last_beat = accept && ((cnt_q + CNT_W'(1)) == len_q);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    act_lane #(
      .DATA_W    (DATA_W),
      .LEAK_SHIFT(LEAK_SHIFT)
    ) u_lane (
      .x_i   (neuron[g*DATA_W +: DATA_W]),
      .mode_i(mode_q),
      .cap_i (cap_q),
      .y_o   (act_w[g*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (layer_len == '0) ? DONE : RUN;
      RUN:     if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    len_d  = len_q;
    mode_d = mode_q;
    cap_d  = cap_q;
    out_d  = out_q;
    vld_d  = accept;
    err_d  = err_q;
    if (start_ok) begin
      cnt_d  = '0;
      len_d  = layer_len;
      mode_d = mode;
      cap_d  = cap;
      err_d  = 1'b0;
    end
    if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
      out_d = act_w;
    end
    // A dropped beat wins over the clear from a same-cycle start.
    if (neuron_done && (state_q != RUN)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= '0;
      cap_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      cap_q   <= cap_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign out             = out_q;
  assign cpu_neuron_done = vld_q;
  assign layer_done      = (state_q == DONE);
  assign busy            = (state_q == RUN);
  assign err             = err_q;

endmodule

// File: tb/tb_act_unit.sv
// Directed bench for act_unit: stimulus pushes expected beats into a queue,
// a monitor pops and compares on every cpu_neuron_done.
module tb_act_unit;

  localparam int DATA_W = 16;
  localparam int LANES  = 4;
  localparam int CNT_W  = 10;
  localparam int W      = LANES*DATA_W + 1;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic [1:0]              mode;
  logic [DATA_W-1:0]       cap;
  logic [CNT_W-1:0]        layer_len;
  logic                    neuron_done;
  logic [LANES*DATA_W-1:0] neuron;
  logic [LANES*DATA_W-1:0] out;
  logic                    cpu_neuron_done;
  logic                    layer_done;
  logic                    busy;
  logic                    err;

  logic [W-1:0] exp_q[$];
  int pass_cnt;
  int check_cnt;

  act_unit #(
    .DATA_W(DATA_W), .LANES(LANES), .LEAK_SHIFT(3), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .cap(cap),
    .layer_len(layer_len), .neuron_done(neuron_done), .neuron(neuron),
    .out(out), .cpu_neuron_done(cpu_neuron_done), .layer_done(layer_done),
    .busy(busy), .err(err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [LANES*DATA_W-1:0] pack4(input int a, input int b,
                                                    input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic check(input string name, input logic [LANES*DATA_W-1:0] got,
                       input logic [LANES*DATA_W-1:0] want);
    check_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Returns with the design one cycle into the new layer.
  task automatic do_start(input logic [1:0] m, input int c, input int len);
    cyc();
    start = 1'b1; mode = m; cap = 16'(c); layer_len = CNT_W'(len);
    cyc();
    start = 1'b0;
  endtask

  task automatic beat(input logic [LANES*DATA_W-1:0] vec,
                      input logic [LANES*DATA_W-1:0] want, input logic last);
    neuron_done = 1'b1;
    neuron      = vec;
    exp_q.push_back({last, want});
    cyc();
    neuron_done = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst && cpu_neuron_done) begin
      if (exp_q.size() == 0) begin
        check_cnt++;
        $display("FAIL unexpected_beat: got out %h with no expected beat", out);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("beat_out", out, e[LANES*DATA_W-1:0]);
        check("beat_layer_done", 64'(layer_done), 64'(e[W-1]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    pass_cnt = 0; check_cnt = 0;
    rst = 1'b0; start = 1'b0; mode = '0; cap = '0; layer_len = '0;
    neuron_done = 1'b0; neuron = '0;
    #12;
    check("rst_out", out, '0);
    check("rst_flags", 64'({cpu_neuron_done, layer_done, busy, err}), 64'(0));
    @(negedge clk); rst = 1'b1;

    // ReLU, single beat
    do_start(2'd1, 0, 1);
    check("run_busy", 64'(busy), 64'(1));
    beat(pack4(-5, 0, 7, 32'h8000), pack4(0, 0, 7, 0), 1'b1);
    check("len1_busy_drop", 64'(busy), 64'(0));

    // leaky ReLU
    do_start(2'd2, 0, 1);
    beat(pack4(-16, -1, -9, 100), pack4(-2, -1, -2, 100), 1'b1);

    // clamp, positive then negative ceiling
    do_start(2'd3, 50, 1);
    beat(pack4(-3, 49, 50, 51), pack4(0, 49, 50, 50), 1'b1);
    do_start(2'd3, -1, 1);
    beat(pack4(-3, 49, 50, 32'h7fff), pack4(0, 0, 0, 0), 1'b1);

    // bypass, four back-to-back beats
    do_start(2'd0, 0, 4);
    beat(pack4(1, -2, 3, -4), pack4(1, -2, 3, -4), 1'b0);
    beat(pack4(32'h8000, 32'h7fff, 0, -1), pack4(32'h8000, 32'h7fff, 0, -1), 1'b0);
    beat(pack4(10, 20, 30, 40), pack4(10, 20, 30, 40), 1'b0);
    check("len4_3_busy", 64'({busy, layer_done}), 64'(2'b10));
    beat(pack4(-7, 7, -8, 8), pack4(-7, 7, -8, 8), 1'b1);
    check("len4_4_busy", 64'({busy, layer_done}), 64'(2'b01));
    cyc();
    check("done_to_idle", 64'({busy, layer_done}), 64'(0));

    // error paths
    check("err_clear0", 64'(err), 64'(0));
    neuron_done = 1'b1; neuron = pack4(1, 1, 1, 1);
    cyc();
    neuron_done = 1'b0;
    check("err_idle_beat", 64'({err, cpu_neuron_done}), 64'(2'b10));
    do_start(2'd1, 0, 2);
    check("err_cleared_by_start", 64'(err), 64'(0));
    beat(pack4(-1, 2, -3, 4), pack4(0, 2, 0, 4), 1'b0);
    beat(pack4(5, -6, 7, -8), pack4(5, 0, 7, 0), 1'b1);
    cyc();
    start = 1'b1; mode = 2'd1; layer_len = CNT_W'(2);
    neuron_done = 1'b1; neuron = pack4(9, 9, 9, 9);
    cyc();
    start = 1'b0; neuron_done = 1'b0;
    check("err_beat_with_start", 64'({err, busy, cpu_neuron_done}), 64'(3'b110));
    beat(pack4(3, -3, 3, -3), pack4(3, 0, 3, 0), 1'b0);
    beat(pack4(-9, 9, -9, 9), pack4(0, 9, 0, 9), 1'b1);
    do_start(2'd1, 0, 0);
    check("len0_done", 64'({layer_done, busy, err, cpu_neuron_done}), 64'(4'b1000));
    cyc();
    check("len0_idle", 64'(layer_done), 64'(0));
    start = 1'b1; layer_len = '0; neuron_done = 1'b1;
    cyc();
    start = 1'b0; neuron_done = 1'b0;
    check("len0_with_beat", 64'({layer_done, err, cpu_neuron_done}), 64'(3'b110));

    // reset mid-layer
    do_start(2'd0, 0, 5);
    beat(pack4(11, 12, 13, 14), pack4(11, 12, 13, 14), 1'b0);
    beat(pack4(21, 22, 23, 24), pack4(21, 22, 23, 24), 1'b0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_out", out, '0);
    check("abort_flags", 64'({cpu_neuron_done, layer_done, busy, err}), 64'(0));
    @(negedge clk); rst = 1'b1;
    do_start(2'd1, 0, 2);
    beat(pack4(-1, 1, -2, 2), pack4(0, 1, 0, 2), 1'b0);
    beat(pack4(100, -100, 0, 5), pack4(100, 0, 0, 5), 1'b1);
    repeat (3) cyc();

    check_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/act_unit.md
Name: act_unit

Overview:
Parametrised multi-lane activation stage between the neuron accumulators and the CPU/next-layer buffer. It applies a run-time-selectable activation (bypass, ReLU, leaky ReLU, clamped ReLU) to LANES signed fixed-point neurons per beat with one-cycle latency. It also tracks how many beats a layer contains and raises a one-cycle layer_done when the programmed count has been processed.

Parameters:
DATA_W, 16, width of one signed two's-complement neuron value
LANES, 4, neurons processed per beat
LEAK_SHIFT, 3, leaky-ReLU negative slope = 2^-LEAK_SHIFT (arithmetic right shift)
CNT_W, 10, width of layer beat counter / layer_len

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: latch mode/cap/layer_len, begin a layer
mode  in  2  activation select: 0 bypass, 1 ReLU, 2 leaky ReLU, 3 clamped ReLU
cap  in  DATA_W  clamp ceiling for mode 3 (signed)
layer_len  in  CNT_W  beats in the layer
neuron_done  in  1  input beat valid
neuron  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
out  out  LANES*DATA_W  activated lanes, same packing
cpu_neuron_done  out  1  out valid, high exactly one cycle per accepted beat
layer_done  out  1  one-cycle pulse at layer end
busy  out  1  high in RUN
err  out  1  sticky: beat arrived while not in RUN

Behaviour:
- Reset (rst=0, async): state IDLE, out=0, cpu_neuron_done=0, layer_done=0, busy=0, err=0, counter=0, latched config=0.
- FSM IDLE->RUN on start (layer_len!=0); IDLE->DONE on start with layer_len==0; RUN->DONE when beat number layer_len is accepted; DONE->IDLE unconditionally after one cycle.
- start latches mode, cap, layer_len, clears counter and err; config held constant until next start. start outside IDLE is ignored.
- Beat accepted only when state==RUN and neuron_done=1. Accepted at cycle t -> out updated and cpu_neuron_done=1 at t+1. Otherwise cpu_neuron_done=0 and out holds its last value.
- neuron_done in IDLE or DONE (including the same cycle as start): beat dropped, err set to 1 next cycle.
- layer_done = (state==DONE); for the last beat it coincides with that beat's cpu_neuron_done. busy = (state==RUN).
- Back-to-back beats every cycle supported; no backpressure.
- Per-lane arithmetic (x signed DATA_W, result DATA_W, no widening):
  mode 0: x
  mode 1: x<0 ? 0 : x
  mode 2: x<0 ? x>>>LEAK_SHIFT : x (floor rounding, -1>>>3 = -1)
  mode 3: x<0 ? 0 : (x>cap ? cap : x); if cap<0, result 0 for all x
- Counter counts accepted beats; compare against latched layer_len; no wrap possible since RUN exits at layer_len.
- Reset asserted mid-layer aborts immediately to reset values; no layer_done emitted.

Decomposition:
- Package act_pkg: mode localparams (ACT_BYPASS, ACT_RELU, ACT_LEAKY, ACT_CLAMP), FSM state encodings (IDLE, RUN, DONE).
- Sub-module act_lane: combinational single-lane activation (x, mode, cap -> y), instantiated LANES times by generate; act_unit owns FSM, counter, registers.

Test Plan:
- Reset then start mode=1 len=1, beat lanes {-5,0,7,0x8000} -> next cycle out {0,0,7,0}, cpu_neuron_done=1, layer_done=1.
- Mode 2 LEAK_SHIFT=3, lanes {-16,-1,-9,100} -> {-2,-1,-2,100}.
- Mode 3 cap=50, lanes {-3,49,50,51} -> {0,49,50,50}; cap=-1 -> all 0.
- len=4, beats on 4 consecutive cycles -> 4 consecutive cpu_neuron_done, layer_done only with 4th, busy drops same cycle.
- Beat in IDLE, beat with start, start with len=0 -> err=1, no cpu_neuron_done; len=0 gives layer_done one cycle after start; next start clears err.
- rst low after 2 of 5 beats -> all outputs 0 immediately; following start len=2 runs normally.
